// File: rtl/ch_capture_pkg.sv
// Shared types and helpers for the multi-channel capture buffer.
package ch_capture_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPrefill,
    StWaitTrig,
    StPost,
    StDone
  } cap_state_e;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ch_capture_ram.sv
// One channel bank: simple dual-port RAM, DEPTH x DATA_W, registered read port.
module ch_capture_ram
  import ch_capture_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [Depth];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Output register only loads on a read so the last result is held.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/ch_capture_buf.sv
// Multi-channel pre/post-trigger capture buffer with window-relative readout.
// Optional trigger timestamp output enabled by defining CH_CAPTURE_TIMESTAMP_EN.
module ch_capture_buf
  import ch_capture_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned NCH    = 4,
  localparam int unsigned CH_W  = ch_width(NCH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  arm,
  input  logic [ADDR_W-1:0]     pre_len,
  input  logic                  s_valid,
  input  logic [NCH*DATA_W-1:0] s_data,
  input  logic                  trig,
  output logic                  busy,
  output logic                  trig_seen,
  output logic                  done,
  output logic [ADDR_W-1:0]     win_start,
  input  logic                  rd_en,
  input  logic [CH_W-1:0]       rd_ch,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic                  rd_valid,
  output logic [DATA_W-1:0]     rd_data
`ifdef CH_CAPTURE_TIMESTAMP_EN
  ,
  output logic [31:0]           trig_ts
`endif
);

  localparam logic [ADDR_W:0] DepthC = {1'b1, {ADDR_W{1'b0}}};

  cap_state_e        state_q;
  logic [ADDR_W-1:0] wr_ptr_q, pre_cnt_q, pre_len_q, win_start_q;
  logic [ADDR_W:0]   post_cnt_q;
  logic              busy_q, done_q, trig_seen_q, rd_valid_q;
  logic [CH_W-1:0]   rd_ch_q;

  logic              capturing, wr_en, trig_hit, rd_accept;
  logic [ADDR_W-1:0] pre_cnt_inc, rd_phys;
  logic [ADDR_W:0]   post_len, post_cnt_inc;
  logic [DATA_W-1:0] bank_q [NCH];

  assign capturing    = (state_q == StPrefill) || (state_q == StWaitTrig) || (state_q == StPost);
  // arm wins: the sample presented alongside arm is dropped.
  assign wr_en        = capturing & s_valid & ~arm;
  assign trig_hit     = wr_en & trig & (state_q == StWaitTrig);
  assign pre_cnt_inc  = pre_cnt_q + 1'b1;
  assign post_len     = DepthC - {1'b0, pre_len_q};
  assign post_cnt_inc = post_cnt_q + 1'b1;
  assign rd_accept    = rd_en & (state_q == StDone);
  assign rd_phys      = win_start_q + rd_addr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      pre_cnt_q   <= '0;
      pre_len_q   <= '0;
      post_cnt_q  <= '0;
      win_start_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      trig_seen_q <= 1'b0;
    end else if (arm) begin
      state_q     <= (pre_len == '0) ? StWaitTrig : StPrefill;
      wr_ptr_q    <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      pre_len_q   <= pre_len;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      trig_seen_q <= 1'b0;
    end else if (wr_en) begin
      wr_ptr_q <= wr_ptr_q + 1'b1;
      unique case (state_q)
        StPrefill: begin
          pre_cnt_q <= pre_cnt_inc;
          if (pre_cnt_inc == pre_len_q) begin
            state_q <= StWaitTrig;
          end
        end
        StWaitTrig: begin
          if (trig) begin
            win_start_q <= wr_ptr_q - pre_len_q;
            trig_seen_q <= 1'b1;
            post_cnt_q  <= {{ADDR_W{1'b0}}, 1'b1};
            // A one-sample post window completes on the trigger write itself.
            if (pre_len_q == '1) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= StPost;
            end
          end
        end
        StPost: begin
          post_cnt_q <= post_cnt_inc;
          if (post_cnt_inc == post_len) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q <= 1'b0;
      rd_ch_q    <= '0;
    end else begin
      rd_valid_q <= rd_accept;
      if (rd_accept) begin
        rd_ch_q <= rd_ch;
      end
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_bank
    ch_capture_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_ram (
      .clock   (clock),
      .reset_n (reset_n),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr_q),
      .wr_data (s_data[k*DATA_W +: DATA_W]),
      .rd_en   (rd_accept),
      .rd_addr (rd_phys),
      .rd_data (bank_q[k])
    );
  end

  // Unmatched (out-of-range) channel selects fall through to zero.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (rd_ch_q == CH_W'(k)) begin
        rd_data = bank_q[k];
      end
    end
  end

`ifdef CH_CAPTURE_TIMESTAMP_EN
  logic [31:0] ts_cnt_q, trig_ts_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ts_cnt_q  <= '0;
      trig_ts_q <= '0;
    end else if (arm) begin
      ts_cnt_q  <= '0;
      trig_ts_q <= '0;
    end else if (wr_en) begin
      ts_cnt_q <= ts_cnt_q + 32'd1;
      if (trig_hit) begin
        trig_ts_q <= ts_cnt_q;
      end
    end
  end

  assign trig_ts = trig_ts_q;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign trig_seen = trig_seen_q;
  assign win_start = win_start_q;
  assign rd_valid  = rd_valid_q;

endmodule
